// File: rtl/sparc_control_unit_pkg.sv
// Shared encodings for the SPARC control unit: FSM states, forced ALU opcodes, error codes, IR fields.
// Latency: n/a (constants and types only); backpressure: n/a.
package sparc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST0     = 4'd0,
        S_RST1     = 4'd1,
        S_FETCH0   = 4'd2,
        S_FETCH1   = 4'd3,
        S_DECODE   = 4'd4,
        S_EXEC_ALU = 4'd5,
        S_LD0      = 4'd6,
        S_LD1      = 4'd7,
        S_LD2      = 4'd8,
        S_ST0      = 4'd9,
        S_ST1      = 4'd10,
        S_ST2      = 4'd11,
        S_BRANCH   = 4'd12,
        S_PCUPD    = 4'd13,
        S_ERROR    = 4'd14
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_PASSA = 6'h3D;
    localparam logic [5:0] OP_PASSB = 6'h3E;

    localparam logic [1:0] TYPE_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] OP_BRANCH     = 2'b00;
    localparam logic [1:0] OP_ARITH      = 2'b10;
    localparam logic [1:0] OP_MEM        = 2'b11;
    localparam logic [2:0] OP2_BICC      = 3'b010;
    localparam logic [5:0] OP3_LD        = 6'h00;
    localparam logic [5:0] OP3_ST        = 6'h04;
    localparam logic [5:0] OP3_ALU_LIMIT = 6'h30;

    typedef struct packed {
        logic       IR_Ld;
        logic       MAR_Ld;
        logic       MDR_Ld;
        logic       PC_Ld;
        logic       NPC_Ld;
        logic       nPC_Clr;
        logic       FR_Ld;
        logic       RF_Load_Enable;
        logic       Register_Windows_Enable;
        logic       MOV;
        logic       RW;
        logic [1:0] Type;
        logic [1:0] MA;
        logic [1:0] MB;
        logic [1:0] MNP;
        logic [1:0] MP;
        logic [1:0] MSc;
        logic       MC;
        logic       MM;
        logic       MOP;
        logic       MSa;
        logic [5:0] OpXX;
        logic       Halt;
    } ctrl_t;

    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH1) || (s == S_LD1) || (s == S_ST2);
    endfunction

endpackage

// File: rtl/sparc_control_unit_if.sv
// Control-unit <-> datapath/RAM bundle: IR, RAM handshake, branch condition and all datapath strobes.
// Latency: wiring only; backpressure: RAM stalls the control unit by withholding MOC.
interface sparc_ctrl_if;
    logic [31:0] IR;
    logic        MOC;
    logic        BCOND;

    logic        IR_Ld;
    logic        MAR_Ld;
    logic        MDR_Ld;
    logic        PC_Ld;
    logic        NPC_Ld;
    logic        nPC_Clr;
    logic        FR_Ld;
    logic        RF_Load_Enable;
    logic        Register_Windows_Enable;
    logic        MOV;
    logic        RW;
    logic [1:0]  Type;
    logic [1:0]  MA;
    logic [1:0]  MB;
    logic [1:0]  MNP;
    logic [1:0]  MP;
    logic [1:0]  MSc;
    logic        MC;
    logic        MM;
    logic        MOP;
    logic        MSa;
    logic [5:0]  OpXX;
    logic        Halt;
    logic [1:0]  Err_Code;

    modport master (
        input  IR, MOC, BCOND,
        output IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld,
               RF_Load_Enable, Register_Windows_Enable, MOV, RW, Type,
               MA, MB, MNP, MP, MSc, MC, MM, MOP, MSa, OpXX, Halt, Err_Code
    );

    modport slave (
        output IR, MOC, BCOND,
        input  IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld,
               RF_Load_Enable, Register_Windows_Enable, MOV, RW, Type,
               MA, MB, MNP, MP, MSc, MC, MM, MOP, MSa, OpXX, Halt, Err_Code
    );
endinterface

// File: rtl/sparc_control_unit_moc_timeout_counter.sv
// Counts consecutive wait cycles without MOC; flags the cycle whose increment would reach LIMIT.
// Latency: o_expired is combinational on the current count; backpressure: none.
module moc_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic Clk,
    input  logic Clr_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == CNT_LAST);
endmodule

// File: rtl/sparc_control_unit.sv
// Hard-wired fetch/decode/execute sequencer driving every SPARC datapath strobe and mux select.
// Latency: ALU/Bicc 5 cycles, LD/ST 7 with MOC on the first wait cycle; backpressure: waits on MOC, errors after MOC_TIMEOUT.
module sparc_control_unit
    import sparc_ctrl_pkg::*;
#(
    parameter int MOC_TIMEOUT = 16
) (
    input logic          Clk,
    input logic          Clr_n,
    sparc_ctrl_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_err;
    logic [1:0] w_err_next;
    logic       r_br_taken;
    ctrl_t      w_ctl;

    logic [1:0] w_op;
    logic [2:0] w_op2;
    logic [5:0] w_op3;
    logic [1:0] w_opb_sel;
    logic       w_in_wait;
    logic       w_expired;
    logic       w_unused_ir;

    assign w_op        = bus.IR[31:30];
    assign w_op2       = bus.IR[24:22];
    assign w_op3       = bus.IR[24:19];
    assign w_opb_sel   = {1'b0, bus.IR[13]};
    assign w_in_wait   = is_mem_wait(r_state);
    assign w_unused_ir = ^{bus.IR[29:25], bus.IR[18:14], bus.IR[12:0]};

    moc_timeout_counter #(
        .LIMIT (MOC_TIMEOUT)
    ) u_moc_tmo (
        .Clk       (Clk),
        .Clr_n     (Clr_n),
        .i_clr     (!w_in_wait),
        .i_en      (w_in_wait && !bus.MOC),
        .o_expired (w_expired)
    );

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state    <= S_RST0;
            r_err      <= ERR_NONE;
            r_br_taken <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_err      <= w_err_next;
            // Only meaningful in the PCUPD that directly follows BRANCH.
            r_br_taken <= (r_state == S_BRANCH) && bus.BCOND;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err;
        w_ctl      = '0;
        w_ctl.Type = TYPE_WORD;

        case (r_state)
            S_RST0: begin
                w_ctl.nPC_Clr = 1'b1;
                w_ctl.PC_Ld   = 1'b1;
                w_ctl.MP      = 2'd0;
                w_next        = S_RST1;
            end
            S_RST1: begin
                w_ctl.NPC_Ld = 1'b1;
                w_ctl.MNP    = 2'd3;
                w_next       = S_FETCH0;
            end
            S_FETCH0: begin
                w_ctl.MC     = 1'b0;
                w_ctl.MB     = 2'd2;
                w_ctl.MOP    = 1'b1;
                w_ctl.OpXX   = OP_PASSB;
                w_ctl.MAR_Ld = 1'b1;
                w_next       = S_FETCH1;
            end
            S_FETCH1: begin
                w_ctl.MOV   = 1'b1;
                w_ctl.RW    = 1'b1;
                w_ctl.IR_Ld = bus.MOC;
                if (bus.MOC) begin
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (w_op == OP_ARITH && w_op3 < OP3_ALU_LIMIT) begin
                    w_next = S_EXEC_ALU;
                end else if (w_op == OP_MEM && w_op3 == OP3_LD) begin
                    w_next = S_LD0;
                end else if (w_op == OP_MEM && w_op3 == OP3_ST) begin
                    w_next = S_ST0;
                end else if (w_op == OP_BRANCH && w_op2 == OP2_BICC) begin
                    w_next = S_BRANCH;
                end else begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_ILLEGAL;
                end
            end
            S_EXEC_ALU: begin
                w_ctl.MB             = w_opb_sel;
                w_ctl.RF_Load_Enable = 1'b1;
                w_ctl.FR_Ld          = bus.IR[23];
                w_next               = S_PCUPD;
            end
            S_LD0, S_ST0: begin
                w_ctl.MB     = w_opb_sel;
                w_ctl.MOP    = 1'b1;
                w_ctl.OpXX   = OP_ADD;
                w_ctl.MAR_Ld = 1'b1;
                w_next       = (r_state == S_LD0) ? S_LD1 : S_ST1;
            end
            S_LD1: begin
                w_ctl.MOV    = 1'b1;
                w_ctl.RW     = 1'b1;
                w_ctl.MM     = 1'b0;
                w_ctl.MDR_Ld = bus.MOC;
                if (bus.MOC) begin
                    w_next = S_LD2;
                end else if (w_expired) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            S_LD2: begin
                w_ctl.MB             = 2'd3;
                w_ctl.MOP            = 1'b1;
                w_ctl.OpXX           = OP_PASSB;
                w_ctl.RF_Load_Enable = 1'b1;
                w_next               = S_PCUPD;
            end
            S_ST1: begin
                w_ctl.MSa    = 1'b1;
                w_ctl.MA     = 2'd0;
                w_ctl.MOP    = 1'b1;
                w_ctl.OpXX   = OP_PASSA;
                w_ctl.MM     = 1'b1;
                w_ctl.MDR_Ld = 1'b1;
                w_next       = S_ST2;
            end
            S_ST2: begin
                w_ctl.MOV = 1'b1;
                w_ctl.RW  = 1'b0;
                if (bus.MOC) begin
                    w_next = S_PCUPD;
                end else if (w_expired) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            S_BRANCH: begin
                w_ctl.MNP    = 2'd2;
                w_ctl.NPC_Ld = bus.BCOND;
                w_next       = S_PCUPD;
            end
            S_PCUPD: begin
                w_ctl.MP     = 2'd3;
                w_ctl.PC_Ld  = 1'b1;
                w_ctl.MNP    = 2'd3;
                w_ctl.NPC_Ld = !r_br_taken;
                w_next       = S_FETCH0;
            end
            S_ERROR: begin
                w_ctl.Halt = 1'b1;
            end
            default: begin
                w_next = S_ERROR;
            end
        endcase
    end

    assign bus.IR_Ld                   = w_ctl.IR_Ld;
    assign bus.MAR_Ld                  = w_ctl.MAR_Ld;
    assign bus.MDR_Ld                  = w_ctl.MDR_Ld;
    assign bus.PC_Ld                   = w_ctl.PC_Ld;
    assign bus.NPC_Ld                  = w_ctl.NPC_Ld;
    assign bus.nPC_Clr                 = w_ctl.nPC_Clr;
    assign bus.FR_Ld                   = w_ctl.FR_Ld;
    assign bus.RF_Load_Enable          = w_ctl.RF_Load_Enable;
    assign bus.Register_Windows_Enable = w_ctl.Register_Windows_Enable;
    assign bus.MOV                     = w_ctl.MOV;
    assign bus.RW                      = w_ctl.RW;
    assign bus.Type                    = w_ctl.Type;
    assign bus.MA                      = w_ctl.MA;
    assign bus.MB                      = w_ctl.MB;
    assign bus.MNP                     = w_ctl.MNP;
    assign bus.MP                      = w_ctl.MP;
    assign bus.MSc                     = w_ctl.MSc;
    assign bus.MC                      = w_ctl.MC;
    assign bus.MM                      = w_ctl.MM;
    assign bus.MOP                     = w_ctl.MOP;
    assign bus.MSa                     = w_ctl.MSa;
    assign bus.OpXX                    = w_ctl.OpXX;
    assign bus.Halt                    = w_ctl.Halt;
    assign bus.Err_Code                = r_err;
endmodule

// File: doc/sparc_control_unit.md
# sparc_control_unit

Hard-wired control unit for the SPARC datapath. It drives every load enable, mux select and memory strobe of the datapath through a fetch / decode / execute sequence. It waits on the RAM handshake (MOV/MOC) with a bounded timeout and consumes BCOND for conditional branches. It supports ALU register/immediate ops, LD, ST and Bicc; any other opcode halts the core with an error flag.

## Interface

Parameters:
- MOC_TIMEOUT, 16: maximum cycles MOV may stay asserted without MOC before entering ERROR.

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Clr_n  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents (datapath wIROut)
- MOC  in  1  memory operation complete from RAM
- BCOND  in  1  branch condition result from condition tester
- IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld  out  1 each  register strobes
- RF_Load_Enable, Register_Windows_Enable  out  1 each  register file write / window enable
- MOV, RW  out  1 each  memory valid; RW=1 read, RW=0 write
- type  out  2  memory access size; always TYPE_WORD
- MA, MB, MNP, MP, MSc  out  2 each  mux selects
- MC, MM, MOP, MSa  out  1 each  mux selects
- OpXX  out  6  forced ALU opcode when MOP=1
- Halt  out  1  core stopped (ERROR state)
- Err_Code  out  2  00 none, 01 illegal opcode, 10 memory timeout

## Operation

- Moore FSM. All outputs decode from the state register, except IR_Ld/MDR_Ld in memory-wait states (gated by MOC) and NPC_Ld in BRANCH (gated by BCOND).
- Unlisted outputs are 0 in every state.
- RST0: nPC_Clr=1, PC_Ld=1 with MP=0 (PC←0). Next: RST1.
- RST1: NPC_Ld=1 with MNP=3 (NPC←0+4). Next: FETCH0.
- FETCH0: MAR←PC. MC=0, MB=2, MOP=1, OpXX=OP_PASSB, MAR_Ld=1. Next: FETCH1.
- FETCH1: MOV=1, RW=1. IR_Ld=MOC. MOC → DECODE. Timeout → ERROR(10).
- DECODE:
  - IR[31:30]=10 and op3<6'h30 → EXEC_ALU.
  - 11 with op3=000000 → LD0.
  - 11 with op3=000100 → ST0.
  - 00 with op2=010 → BRANCH.
  - Anything else → ERROR(01).
- Operand B select for ALU and address states: MB=1 (sign-extended immediate) if IR[13]=1, else MB=0.
- EXEC_ALU: MSa=0, MSc=0, MOP=0, RF_Load_Enable=1, FR_Ld=IR[23] (cc variant). Next: PCUPD.
- LD0: MAR←rs1+opB with MOP=1, OpXX=OP_ADD, MAR_Ld=1. Next: LD1.
- LD1: MOV=1, RW=1, MM=0, MDR_Ld=MOC. MOC → LD2.
- LD2: rd←MDR. MB=3, MOP=1, OpXX=OP_PASSB, RF_Load_Enable=1. Next: PCUPD.
- ST0: as LD0. Next: ST1.
- ST1: MDR←rd. MSa=1, MA=0, OpXX=OP_PASSA, MM=1, MDR_Ld=1. Next: ST2.
- ST2: MOV=1, RW=0. MOC → PCUPD.
- BRANCH: MNP=2, NPC_Ld=BCOND (NPC←PC+disp). Next: PCUPD.
- PCUPD: PC←NPC (MP=3, PC_Ld=1). NPC←NPC+4 (MNP=3, NPC_Ld=1), except after a taken branch, where NPC is left unchanged. Next: FETCH0.
- ERROR: Halt=1, Err_Code held, all strobes 0. Leaves only on reset.
- Timeout counter: cleared on entry to any memory-wait state, increments each cycle MOC=0. Reaching MOC_TIMEOUT → ERROR(10). MOC in the same cycle as the counter reaching its limit wins (normal completion).

## Timing

- Clr_n low: state RST0 immediately (asynchronous), all outputs 0 except the RST0 decode. Halt=0, Err_Code=00, counter=0.
- Reset mid-memory-access drops MOV within the same reset assertion.
- Minimum instruction latency, with MOC in the first wait cycle:
  - ALU: 4 cycles (FETCH0, FETCH1, DECODE, EXEC_ALU) plus PCUPD = 5.
  - LD: 7.
  - ST: 7.
  - Bicc: 5.
- MOV is held continuously through a wait state until MOC is sampled high. There is no MOV gap between back-to-back wait cycles.

## Structure

- Package sparc_ctrl_pkg holds:
  - state encoding (enumerated localparams);
  - OP_PASSA, OP_PASSB, OP_ADD opcode constants;
  - TYPE_WORD;
  - Err_Code values;
  - opcode field constants (OP_ARITH, OP_MEM, OP2_BICC, OP3_LD, OP3_ST).
- One sub-module: moc_timeout_counter (clear, enable, limit → expired).

## Test plan

- Reset, then MOC on the first wait cycle with IR=add r1,r2,r3: sequence RST0, RST1, FETCH0, FETCH1, DECODE, EXEC_ALU, PCUPD. RF_Load_Enable pulses once. PC_Ld with MP=3 in cycle 7.
- LD with IR[13]=1, simm13=8, MOC delayed 3 cycles: MOV high 4 consecutive cycles in LD1. MDR_Ld coincides with MOC. RF_Load_Enable with MB=3 one cycle later.
- Bicc with BCOND=1, then BCOND=0: NPC_Ld with MNP=2 only in the first case. PCUPD NPC_Ld is 0 after the taken branch and 1 after the untaken one.
- MOC never asserted, MOC_TIMEOUT=16: ERROR entered 16 cycles after FETCH1. Halt=1, Err_Code=10, MOV=0 thereafter.
- IR[31:30]=01 (CALL): ERROR with Err_Code=01 on the cycle after DECODE.
- Clr_n pulsed low during ST2 wait: MOV drops asynchronously. FSM restarts at RST0, Halt=0.
